// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes
// and the datapath mux-select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_JMP, S_UPPER
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_controller_imm_decoder.sv
// Combinational opcode -> immediate-format select; I-format for everything
// that is not S/B/J/U.
module mc_imm_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:        imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory port
// and register file, with an optional per-access memory wait limit.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       BranchTaken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_error
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WLIM = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] WMAX = '1;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q;
  logic            timeout;
  logic            req, we, adr, irw, pcw, rw, ret, ill, berr;
  logic [1:0]      srca, srcb, aluop, res;

  assign timeout = (WAIT_LIMIT != 0) && (wcnt_q == WLIM) &&
                   (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE});

  mc_imm_decoder u_imm (.op(Op), .imm_src(ImmSrc));

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;

  // Any state change (or an abandoned access) starts a fresh wait count.
  always_ff @(posedge clk or posedge rst)
    if (rst)                               wcnt_q <= '0;
    else if (state_d != state_q || timeout) wcnt_q <= '0;
    else if (req && !mem_ready && wcnt_q != WMAX) wcnt_q <= wcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    req = 1'b0; we = 1'b0; adr = 1'b0; irw = 1'b0; pcw = 1'b0;
    rw = 1'b0; ret = 1'b0; ill = 1'b0; berr = 1'b0;
    srca = SRCA_PC; srcb = SRCB_RS2; aluop = ALU_ADD; res = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        req = 1'b1; srcb = SRCB_FOUR; res = RES_ALURES;
        if (mem_ready) begin irw = 1'b1; pcw = 1'b1; state_d = S_DECODE; end
      end
      S_DECODE: begin
        srca = SRCA_OLDPC; srcb = SRCB_IMM;
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin ill = 1'b1; state_d = S_FETCH; end
        endcase
      end
      S_MEMADR: begin
        srca = SRCA_RS1; srcb = SRCB_IMM;
        state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        req = 1'b1; adr = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res = RES_MEM; rw = 1'b1; ret = 1'b1; state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        req = 1'b1; we = 1'b1; adr = 1'b1;
        if (mem_ready) begin ret = 1'b1; state_d = S_FETCH; end
      end
      S_EXECUTER: begin
        srca = SRCA_RS1; srcb = SRCB_RS2; aluop = ALU_FUNCT; state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        srca = SRCA_RS1; srcb = SRCB_IMM; aluop = ALU_FUNCT; state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1; ret = 1'b1; state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca = SRCA_RS1; srcb = SRCB_RS2; aluop = ALU_BR;
        pcw = BranchTaken; ret = 1'b1; state_d = S_FETCH;
      end
      S_JAL: begin
        srca = SRCA_OLDPC; srcb = SRCB_FOUR; pcw = 1'b1; state_d = S_ALUWB;
      end
      S_JALR_ADR: begin
        srca = SRCA_RS1; srcb = SRCB_IMM; state_d = S_JALR_JMP;
      end
      S_JALR_JMP: begin
        srca = SRCA_OLDPC; srcb = SRCB_FOUR; pcw = 1'b1; state_d = S_ALUWB;
      end
      S_UPPER: begin
        srca = (Op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC; srcb = SRCB_IMM;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // Abandoned access: drop the request so mem_ready is ignored, no writes.
    if (timeout) begin
      req = 1'b0; we = 1'b0; irw = 1'b0; pcw = 1'b0; ret = 1'b0;
      berr = 1'b1; state_d = S_FETCH;
    end
  end

  assign mem_req    = req  & ~rst;
  assign MemWrite   = we   & ~rst;
  assign IRWrite    = irw  & ~rst;
  assign PCWrite    = pcw  & ~rst;
  assign RegWrite   = rw   & ~rst;
  assign retire     = ret  & ~rst;
  assign illegal_op = ill  & ~rst;
  assign bus_error  = berr & ~rst;
  assign AdrSrc     = adr;
  assign ALUSrcA    = srca;
  assign ALUSrcB    = srcb;
  assign ALUOp      = aluop;
  assign ResultSrc  = res;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction step recipes with directed
// and random memory-ready behaviour, checked every cycle.
module tb_multicycle_controller;

  localparam int WL = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] Op = 7'b0;
  logic BranchTaken = 1'b0, mem_ready = 1'b0;
  logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic retire, illegal_op, bus_error;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;

  multicycle_controller #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .Op(Op), .BranchTaken(BranchTaken),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
    .retire(retire), .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req, we, adr, irw, pcw, rw, ret, ill, berr;
    logic [2:0] imm;
    logic [1:0] srca, srcb, aluop, res;
  } obs_t;

  typedef struct { bit acc; obs_t o; } step_t;

  obs_t  obs;
  step_t rec[$];
  int    n_assert = 0, n_fail = 0;

  assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire,
                illegal_op, bus_error, ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  function automatic logic [2:0] imm_of(logic [6:0] op);
    case (op)
      SW:         return 3'b001;
      BR:         return 3'b010;
      JAL:        return 3'b011;
      LUI, AUIPC: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic obs_t blank(logic [6:0] op);
    obs_t o = '0;
    o.imm = imm_of(op);
    return o;
  endfunction

  // Expected outputs while reset holds the controller in its fetch position.
  function automatic obs_t rst_obs(logic [6:0] op);
    obs_t o = blank(op);
    o.srcb = 2'b10; o.res = 2'b10;
    return o;
  endfunction

  // Step recipe for one instruction; access steps carry their completion strobes.
  function automatic void build(logic [6:0] op, logic bt);
    obs_t s, wb;
    rec.delete();
    s = blank(op); s.req = 1; s.srcb = 2'b10; s.res = 2'b10; s.irw = 1; s.pcw = 1;
    rec.push_back('{acc: 1'b1, o: s});
    s = blank(op); s.srca = 2'b01; s.srcb = 2'b01;
    s.ill = !(op inside {LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC});
    rec.push_back('{acc: 1'b0, o: s});
    wb = blank(op); wb.res = 2'b00; wb.rw = 1; wb.ret = 1;
    case (op)
      LW, SW: begin
        s = blank(op); s.srca = 2'b10; s.srcb = 2'b01;
        rec.push_back('{acc: 1'b0, o: s});
        s = blank(op); s.req = 1; s.adr = 1;
        if (op == SW) begin s.we = 1; s.ret = 1; end
        rec.push_back('{acc: 1'b1, o: s});
        if (op == LW) begin
          s = blank(op); s.res = 2'b01; s.rw = 1; s.ret = 1;
          rec.push_back('{acc: 1'b0, o: s});
        end
      end
      RT, IT: begin
        s = blank(op); s.srca = 2'b10; s.srcb = (op == IT) ? 2'b01 : 2'b00;
        s.aluop = 2'b10;
        rec.push_back('{acc: 1'b0, o: s});
        rec.push_back('{acc: 1'b0, o: wb});
      end
      BR: begin
        s = blank(op); s.srca = 2'b10; s.aluop = 2'b01; s.pcw = bt; s.ret = 1;
        rec.push_back('{acc: 1'b0, o: s});
      end
      JAL, JALR: begin
        if (op == JALR) begin
          s = blank(op); s.srca = 2'b10; s.srcb = 2'b01;
          rec.push_back('{acc: 1'b0, o: s});
        end
        s = blank(op); s.srca = 2'b01; s.srcb = 2'b10; s.pcw = 1;
        rec.push_back('{acc: 1'b0, o: s});
        rec.push_back('{acc: 1'b0, o: wb});
      end
      LUI, AUIPC: begin
        s = blank(op); s.srca = (op == LUI) ? 2'b11 : 2'b01; s.srcb = 2'b01;
        rec.push_back('{acc: 1'b0, o: s});
        rec.push_back('{acc: 1'b0, o: wb});
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk_i(input string tag, input int o, input int e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // One cycle: drive mem_ready, check at negedge, optionally advance.
  task automatic cycle(input obs_t e, input logic rdy, input string tag, input bit adv);
    mem_ready = rdy;
    @(negedge clk);
    chk(tag, obs, e);
    if (adv) begin @(posedge clk); #1; end
  endtask

  // at<0: random readiness; otherwise ready on wait index 'at' (large = never).
  task automatic run(input logic [6:0] op, input logic bt, input int fetch_at,
                     input int data_at, input int stop_at,
                     output int cyc, output bit aborted);
    obs_t  e;
    logic  rdy;
    int    at;
    bit    adv;
    string tag;
    build(op, bt);
    Op = op; BranchTaken = bt;
    cyc = 0; aborted = 0;
    foreach (rec[i]) begin
      tag = $sformatf("op%b/bt%0b/step%0d", op, bt, i);
      if (!rec[i].acc) begin
        adv = (cyc + 1 != stop_at);
        cycle(rec[i].o, 1'($urandom_range(0, 1)), tag, adv);
        cyc++;
        if (!adv) begin aborted = 1; return; end
      end else begin
        at = (i == 0) ? fetch_at : data_at;
        for (int w = 0; w <= WL; w++) begin
          adv = (cyc + 1 != stop_at);
          e = rec[i].o;
          if (w == WL) begin
            e.req = 0; e.we = 0; e.irw = 0; e.pcw = 0; e.ret = 0; e.rw = 0;
            e.berr = 1;
            cycle(e, 1'($urandom_range(0, 1)), {tag, "/timeout"}, adv);
            cyc++;
            aborted = 1;
            return;
          end
          rdy = (at < 0) ? ($urandom_range(0, 99) < 60) : (w == at);
          if (!rdy) begin e.irw = 0; e.pcw = 0; e.ret = 0; e.rw = 0; end
          cycle(e, rdy, $sformatf("%s/w%0d", tag, w), adv);
          cyc++;
          if (!adv) begin aborted = 1; return; end
          if (rdy) break;
        end
      end
    end
  endtask

  initial begin
    int cyc;
    bit ab;
    logic [6:0] ops [11];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC, 7'b1111111, 7'b0000000};

    rst = 1; Op = LW; mem_ready = 1;
    repeat (2) begin
      @(negedge clk);
      chk("reset", obs, rst_obs(LW));
    end
    @(posedge clk); #1;
    rst = 0;

    run(LW, 0, 0, 0, 0, cyc, ab);     chk_i("lat_lw", cyc, 5);
    run(BR, 1, 0, 0, 0, cyc, ab);     chk_i("lat_beq_t", cyc, 3);
    run(BR, 0, 0, 0, 0, cyc, ab);     chk_i("lat_beq_nt", cyc, 3);
    run(JAL, 0, 0, 0, 0, cyc, ab);    chk_i("lat_jal", cyc, 4);
    run(JALR, 0, 0, 0, 0, cyc, ab);   chk_i("lat_jalr", cyc, 5);
    run(SW, 0, 0, 0, 0, cyc, ab);     chk_i("lat_sw", cyc, 4);
    run(RT, 0, 0, 0, 0, cyc, ab);     chk_i("lat_r", cyc, 4);
    run(IT, 0, 0, 0, 0, cyc, ab);     chk_i("lat_i", cyc, 4);
    run(LUI, 0, 0, 0, 0, cyc, ab);    chk_i("lat_lui", cyc, 4);
    run(AUIPC, 0, 0, 0, 0, cyc, ab);  chk_i("lat_auipc", cyc, 4);
    run(7'b1111111, 0, 0, 0, 0, cyc, ab); chk_i("lat_illegal", cyc, 2);

    // Store that never completes: three wait cycles then the abandon cycle.
    run(SW, 0, 0, 99, 0, cyc, ab);
    chk_i("sw_timeout_abort", int'(ab), 1);
    chk_i("sw_timeout_cycles", cyc, 7);
    // Store completing on the second wait cycle.
    run(SW, 0, 0, 1, 0, cyc, ab);
    chk_i("sw_late_abort", int'(ab), 0);
    chk_i("sw_late_cycles", cyc, 5);
    // Instruction fetch that never completes.
    run(LW, 0, 99, 0, 0, cyc, ab);
    chk_i("fetch_timeout_cycles", cyc, 4);
    run(RT, 0, 2, 0, 0, cyc, ab);     chk_i("fetch_late", cyc, 6);

    // Reset during the first MEMREAD wait cycle.
    run(LW, 0, 0, 99, 4, cyc, ab);
    #1 rst = 1;
    #1 chk("reset_mid_memread", obs, rst_obs(LW));
    @(posedge clk); #1;
    rst = 0;
    run(LW, 0, 0, 0, 0, cyc, ab);     chk_i("lat_lw_after_reset", cyc, 5);

    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
      run(op, 1'($urandom_range(0, 1)), -1, -1, 0, cyc, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the RV32I core: sequences one shared ALU, one unified instruction/data memory port and the register file across 3–5+ cycles per instruction. Sits beside the datapath, takes the latched opcode, branch outcome and memory handshake, and drives all mux selects and write enables. It also signals retire, illegal-opcode and memory-timeout events.

## Interface
- WAIT_LIMIT, 0, maximum mem_ready wait cycles per access; 0 = unlimited
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Op  in  7  opcode from instruction register (valid from DECODE onward)
- BranchTaken  in  1  branch condition from datapath compare
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  store strobe (qualifies mem_req)
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- IRWrite  out  1  latch instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- retire  out  1  one-cycle pulse, instruction complete
- illegal_op  out  1  one-cycle pulse, unknown opcode
- bus_error  out  1  one-cycle pulse, WAIT_LIMIT exceeded

## Operation
- Moore FSM, 14 states. Outputs are decoded from state only. The only exceptions are the strobes gated by mem_ready or BranchTaken as listed below.
- Unlisted outputs are 0. ImmSrc is decoded from Op in every state.
- FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCWrite = mem_ready. Next state is DECODE on mem_ready, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01 (precomputes branch target). Next state by Op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADR
  - 0110111/0010111 → UPPER
  - other → FETCH with illegal_op=1
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next state is MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req, AdrSrc=1. Next state is MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite, retire. Next state is FETCH.
- MEMWRITE: mem_req, MemWrite, AdrSrc=1. On mem_ready: retire, next state FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite, retire. Next state is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=BranchTaken, retire. Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite. Next state is ALUWB, which writes OldPC+4.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01. Next state is JALR_JMP.
- JALR_JMP: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite. Next state is ALUWB. The datapath clears target bit 0.
- UPPER: ALUSrcA=11 (lui) or 01 (auipc), ALUSrcB=01. Next state is ALUWB.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE; increments each cycle mem_req=1 and mem_ready=0.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT: bus_error pulses, the access is abandoned and the next state is FETCH.
  - An abandoned access performs no write: IRWrite, PCWrite and RegWrite stay 0, so the same PC is refetched.
- mem_ready is ignored when mem_req=0.

## Timing
- Reset: state=FETCH. While rst=1, every strobe is forced to 0: mem_req, MemWrite, IRWrite, PCWrite, RegWrite, retire, illegal_op, bus_error. The wait counter is 0.
- The first request is issued in the first cycle after rst deasserts.
- rst asserted mid-instruction aborts immediately. The next state after reset is FETCH, with no partial write.
- Zero-wait latency in cycles:
  - lw 5; jalr 5
  - sw, R-type, I-type, jal, lui, auipc 4
  - branch 3
  - illegal 2 (no retire)
- Each mem_ready=0 cycle during an access adds 1 cycle.
- retire occurs in the last cycle of each instruction, exactly once.
- Wait counter width: $clog2(WAIT_LIMIT+1), minimum 1. It saturates and does not wrap.

## Structure
- Shared package: state enum (4-bit), opcode constants, ImmSrc/ALUOp/ALUSrcA/ALUSrcB/ResultSrc encodings.
- One sub-module, mc_imm_decoder: combinational Op → ImmSrc.
- The FSM, wait counter and output decode live in multicycle_controller.

## Test plan
- Reset mid-MEMREAD: assert rst → all strobes 0 at once. On release, FETCH with mem_req=1 and no RegWrite.
- lw (Op=0000011), mem_ready always 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 only in cycle 5, retire once.
- beq (Op=1100011):
  - BranchTaken=1 → PCWrite=1 in cycle 3.
  - BranchTaken=0 → PCWrite=0.
  - Both cases: retire in cycle 3.
- jal then jalr:
  - jal: PCWrite in cycle 3, RegWrite in cycle 4.
  - jalr: ALUSrcA=10/ALUSrcB=01 in cycle 3, PCWrite in cycle 4, RegWrite in cycle 5.
- Op=1111111 → illegal_op pulse in DECODE, back to FETCH, no RegWrite/PCWrite.
- WAIT_LIMIT=3, sw with mem_ready held 0 → bus_error after 3 wait cycles, MemWrite drops, FETCH follows, no retire.
  - Repeat with mem_ready=1 on wait cycle 2 → retire, no bus_error.
